// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: op codes, handshake FSM encoding,
// and a helper that classifies the M-extension op range.
package alu_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    function automatic logic op_is_muldiv(input logic [ALU_OP_W-1:0] op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 mul/div engine (built only with ALU_MULDIV_EN): magnitudes
// in, one shift-add / restoring shift-subtract per cycle, sign fix-up on the last step.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                last,
    output logic [W-1:0]        result
);

    localparam int CW = $clog2(W);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc, lo, mcand;
    logic          is_div, sel_hi, sel_rem, neg;

    logic          a_neg, b_neg;
    logic [W:0]    sum, rs, diff;
    logic [W-1:0]  nacc, nlo;
    logic [2*W-1:0] prod;

    always_comb begin
        a_neg = (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a[W-1];
        b_neg = (op inside {ALU_MULH, ALU_DIV, ALU_REM}) && b[W-1];
    end

    // acc holds the high product half or the partial remainder; lo holds the
    // multiplier being shifted out or the dividend/quotient being shifted through.
    always_comb begin
        sum  = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
        rs   = {acc, lo[W-1]};
        diff = rs - {1'b0, mcand};
        if (is_div) begin
            if (!diff[W]) begin
                nacc = diff[W-1:0];
                nlo  = {lo[W-2:0], 1'b1};
            end else begin
                nacc = rs[W-1:0];
                nlo  = {lo[W-2:0], 1'b0};
            end
        end else begin
            nacc = sum[W:1];
            nlo  = {sum[0], lo[W-1:1]};
        end
        prod = neg ? -{nacc, nlo} : {nacc, nlo};
        if (is_div)
            result = sel_rem ? (neg ? -nacc : nacc) : (neg ? -nlo : nlo);
        else
            result = sel_hi ? prod[2*W-1:W] : prod[W-1:0];
    end

    assign last = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CW'(W - 1);
            acc     <= '0;
            lo      <= a_neg ? -a : a;
            mcand   <= b_neg ? -b : b;
            is_div  <= op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
            sel_hi  <= op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
            sel_rem <= op inside {ALU_REM, ALU_REMU};
            neg     <= (op == ALU_REM) ? a_neg : (a_neg ^ b_neg);
        end else if (busy) begin
            acc <= nacc;
            lo  <= nlo;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// EX-stage integer ALU with valid/ready handshake; base ops registered in one cycle.
// Define ALU_MULDIV_EN to add the iterative M-extension engine (WIDTH+1 cycle latency).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int TAG_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ALU_OP_W-1:0]      in_op,
    input  logic [OPERAND_WIDTH-1:0] in_a,
    input  logic [OPERAND_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_illegal
);

    localparam int W   = OPERAND_WIDTH;
    localparam int SHW = $clog2(W);

    alu_state_t     state, state_n;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   base_res, iter_res;
    logic           base_ill, iter_go, iter_last, accept;

    assign shamt     = in_b[SHW-1:0];
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        iter_go  = 1'b0;
        case (in_op)
            ALU_ADD:  base_res = in_a + in_b;
            ALU_SUB:  base_res = in_a - in_b;
            ALU_XOR:  base_res = in_a ^ in_b;
            ALU_OR:   base_res = in_a | in_b;
            ALU_AND:  base_res = in_a & in_b;
            ALU_SLL:  base_res = in_a << shamt;
            ALU_SRL:  base_res = in_a >> shamt;
            ALU_SRA:  base_res = $signed(in_a) >>> shamt;
            ALU_SLT:  base_res = {{(W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            ALU_SLTU: base_res = {{(W-1){1'b0}}, in_a < in_b};
            default:  base_ill = 1'b1;
        endcase
`ifdef ALU_MULDIV_EN
        // Divide-by-zero and MIN/-1 resolve immediately; everything else iterates.
        if (op_is_muldiv(in_op)) begin
            base_ill = 1'b0;
            if ((in_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) && (in_b == '0))
                base_res = (in_op inside {ALU_DIV, ALU_DIVU}) ? '1 : in_a;
            else if ((in_op inside {ALU_DIV, ALU_REM}) && (in_a == {1'b1, {(W-1){1'b0}}}) && (&in_b))
                base_res = (in_op == ALU_DIV) ? in_a : '0;
            else
                iter_go = 1'b1;
        end
`endif
    end

`ifdef ALU_MULDIV_EN
    alu_muldiv_iter #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (accept && iter_go),
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .last   (iter_last),
        .result (iter_res)
    );
`else
    assign iter_last = 1'b0;
    assign iter_res  = '0;
`endif

    always_comb begin
        state_n = state;
        if (flush)
            state_n = IDLE;
        else if (accept)
            state_n = iter_go ? CALC : DONE;
        else if ((state == CALC) && iter_last)
            state_n = DONE;
        else if ((state == DONE) && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                out_result  <= base_res;
                out_tag     <= in_tag;
                out_illegal <= base_ill;
            end else if ((state == CALC) && iter_last && !flush) begin
                out_result <= iter_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit at WIDTH=32; M-extension vectors
// are selected when ALU_MULDIV_EN is defined.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [4:0]  in_op, in_tag, out_tag;
    logic [31:0] in_a, in_b, out_result;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.OPERAND_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    endtask

    // Issue at a falling edge, then count falling edges until out_valid.
    task automatic run(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] er,
                       input logic ei, input int elat);
        int lat;
        @(negedge clk);
        drive(op, a, b, tag);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " result"}, out_result, er);
        chk({nm, " illegal"}, out_illegal, ei);
        chk({nm, " tag"}, out_tag, tag);
    endtask

    initial begin
        logic [4:0]  s_op;
        logic [31:0] s_a, s_b, s_res;
        int          s_lat, nval;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_result", out_result, 32'h0);
        chk("reset out_tag", out_tag, 5'h0);
        chk("reset out_illegal", out_illegal, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);

        // Back-to-back base ops, one result per cycle.
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd1);
        @(negedge clk);
        chk("b2b add valid", out_valid, 1'b1);
        chk("b2b add result", out_result, 32'h8000_0000);
        chk("b2b in_ready", in_ready, 1'b1);
        drive(ALU_SRA, 32'h8000_0000, 32'd33, 5'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b sra valid", out_valid, 1'b1);
        chk("b2b sra result", out_result, 32'hC000_0000);
        chk("b2b sra tag", out_tag, 5'd2);

        run("sub",  ALU_SUB,  32'd5,         32'd7,         5'd3,  32'hFFFF_FFFE, 1'b0, 1);
        run("xor",  ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4,  32'h0FF0_0FF0, 1'b0, 1);
        run("or",   ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6,  32'hFFF0_FFF0, 1'b0, 1);
        run("and",  ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'hF000_F000, 1'b0, 1);
        run("sll",  ALU_SLL,  32'h1,         32'd31,        5'd8,  32'h8000_0000, 1'b0, 1);
        run("srl",  ALU_SRL,  32'h8000_0000, 32'h24,        5'd9,  32'h0800_0000, 1'b0, 1);
        run("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h1,         5'd10, 32'h1,         1'b0, 1);
        run("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd11, 32'h0,         1'b0, 1);
        run("op20", 5'd20,    32'h1234_5678, 32'h1,         5'd12, 32'h0,         1'b1, 1);

`ifdef ALU_MULDIV_EN
        run("mulh",   ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0,         1'b0, 33);
        run("mulhu",  ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 1'b0, 33);
        run("mul",    ALU_MUL,   32'hFFFF_FFFA, 32'd7,         5'd15, 32'hFFFF_FFD6, 1'b0, 33);
        run("divovf", ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b0, 1);
        run("divu0",  ALU_DIVU,  32'd7,         32'd0,         5'd17, 32'hFFFF_FFFF, 1'b0, 1);
        run("remu0",  ALU_REMU,  32'd7,         32'd0,         5'd18, 32'd7,         1'b0, 1);
        s_op = ALU_REM; s_a = 32'hFFFF_FFF9; s_b = 32'd2; s_res = 32'hFFFF_FFFF; s_lat = 33;
`else
        run("op10",   ALU_MUL,   32'd6,         32'd7,         5'd13, 32'h0,         1'b1, 1);
        run("div ill", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0,         1'b1, 1);
        s_op = ALU_AND; s_a = 32'hF0; s_b = 32'h3C; s_res = 32'h30; s_lat = 1;
`endif

        // Consumer stall: output held stable, no new accept.
        run("stall", s_op, s_a, s_b, 5'd5, s_res, 1'b0, s_lat);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall valid", out_valid, 1'b1);
            chk("stall result", out_result, s_res);
            chk("stall tag", out_tag, 5'd5);
            chk("stall in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;

        // Flush while holding a result, with a request presented the same cycle.
        run("prefl", ALU_XOR, 32'hAAAA_0000, 32'h0000_5555, 5'd19, 32'hAAAA_5555, 1'b0, 1);
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        drive(ALU_ADD, 32'd1, 32'd1, 5'd20);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush valid", out_valid, 1'b0);
        chk("flush no capture", out_result, 32'hAAAA_5555);
        chk("flush tag kept", out_tag, 5'd19);
        @(negedge clk);
        chk("flush still idle", out_valid, 1'b0);
        out_ready = 1'b1;

`ifdef ALU_MULDIV_EN
        // Flush a divide mid-iteration; nothing may emerge for it.
        @(negedge clk);
        drive(ALU_DIV, 32'd1000, 32'd3, 5'd21);
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) nval++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (out_valid) nval++;
        chk("div flushed early", nval, 0);
        run("postfl add", ALU_ADD, 32'd2, 32'd3, 5'd22, 32'd5, 1'b0, 1);
        nval = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nval++;
        end
        chk("div flushed late", nval, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked RV32/RV64 execute unit for the EX stage of the 5-stage pipeline. It implements the ten base integer ALU operations with one-cycle registered latency. Optionally it adds the RISC-V M-extension (MUL/MULH*/DIV*/REM*) as an iterative radix-2 engine taking WIDTH+1 cycles. A valid/ready pair on each side lets the hazard unit stall on multi-cycle ops, and `flush` squashes the in-flight op on a branch mispredict.

## Interface
- `OPERAND_WIDTH`, default 32: operand/result width; power of two, ≥ 8.
- `TAG_WIDTH`, default 5: sideband tag (destination rd), passed through unchanged.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: abort the in-flight op; priority over everything except `rst`.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept this cycle.
- `in_op` input 5: operation code.
- `in_a`, `in_b` input OPERAND_WIDTH: operand1, operand2.
- `in_tag` input TAG_WIDTH: sideband tag.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes the result.
- `out_result` output OPERAND_WIDTH: result.
- `out_tag` output TAG_WIDTH: tag of the result.
- `out_illegal` output 1: op code not implemented; the result is 0.

## Operation
- Op codes:
  - 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
  - 10 mul, 11 mulh, 12 mulhsu, 13 mulhu, 14 div, 15 divu, 16 rem, 17 remu.
  - 18–31 illegal.
- Shifts use only `in_b[log2(OPERAND_WIDTH)-1:0]`. `sra` is arithmetic: the MSB of `in_a` fills vacated bits.
- slt/sltu: result is zero-extended 0/1.
- mul returns the low WIDTH bits. mulh/mulhsu/mulhu return the high WIDTH bits of the 2·WIDTH product; mulhsu treats `in_a` as signed and `in_b` as unsigned.
- Divide by zero:
  - div/divu quotient = all ones.
  - rem/remu = `in_a`.
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
- Signed mul/div: operands are converted to magnitudes, iterated unsigned, then sign-corrected on exit.
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating; `in_ready`=0.
  - DONE: `out_valid`=1; `in_ready` = `out_ready`.
- Accept happens when `in_valid && in_ready`. The operation, operands and tag are captured in the same edge.
  - Base op, illegal op, divide-by-zero or overflow: result is computed and registered; go to DONE.
  - Otherwise (mul/div): load the counter with OPERAND_WIDTH−1; go to CALC.
- CALC: one shift-add (mul) or one restoring shift-subtract (div) step per cycle. When the counter reaches 0, the sign-corrected result is registered and the state moves to DONE.
- DONE: holds `out_result`, `out_tag` and `out_illegal` stable until `out_ready`.
  - On `out_ready` with no new accept, go to IDLE.
  - Accept in the same cycle (back-to-back) goes directly to DONE or CALC per the new op.
- `flush`: next state is IDLE and `out_valid`=0. A simultaneous `in_valid` is dropped; `in_ready` is still driven, but no capture occurs.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_tag`=0, `out_illegal`=0, state=IDLE. `in_ready`=1 in the cycle after reset deasserts.
- Latency is counted from the accept edge to the first cycle with `out_valid`=1:
  - 1 cycle for base, illegal and special-case ops.
  - OPERAND_WIDTH+1 cycles for iterative ops (33 at WIDTH=32).
- Throughput: one base op per cycle when `out_ready` is held high.
- `in_ready` is combinational from state and `out_ready`. It has no path from `in_valid`.
- Reset or flush during CALC discards the partial result. Nothing is emitted for the discarded op.

## Configuration
- `ALU_MULDIV_EN`:
  - Defined: ops 10–17 are implemented as above.
  - Undefined: the iterative engine and the CALC state are not built. Ops 10–17 are treated as illegal (result 0, `out_illegal`=1, latency 1).

## Structure
- Shared package `alu_pkg` holds:
  - op-code localparams (`ALU_ADD` … `ALU_REMU`);
  - the state encoding (IDLE/CALC/DONE);
  - the `ALU_OP_W`=5 width constant.
- Sub-module `alu_muldiv_iter` contains the iterative mul/div datapath:
  - start/busy/done signalling;
  - counter, partial product/remainder registers, sign fix-up.
- `alu_muldiv_iter` is instantiated only under `ALU_MULDIV_EN`. The top-level module owns the handshake FSM and the base-op datapath.

## Test plan
- add 0x7FFFFFFF + 1, then sra 0x80000000 by 33 (uses 1), with `out_ready`=1 → results 0x80000000 then 0xC0000000, on consecutive cycles, latency 1 each.
- mulh 0xFFFFFFFF × 0xFFFFFFFF (−1 × −1) → 0x00000000 after 33 cycles; mulhu of the same operands → 0xFFFFFFFE.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000, latency 1; divu 7 / 0 → 0xFFFFFFFF; remu 7 / 0 → 7.
- rem −7 / 2 → 0xFFFFFFFF with tag 5; hold `out_ready`=0 for 4 cycles → result and tag stay stable, `in_ready`=0.
- Assert `flush` at cycle 10 of a div → `out_valid` never rises for that op; a new add issued 1 cycle later returns after latency 1.
- Op 20 → result 0, `out_illegal`=1. Without `ALU_MULDIV_EN`, op 10 → result 0, `out_illegal`=1.
